// File: rtl/sync_debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_debounce_pkg
//  Description : Shared types and constants for the sync_debounce block:
//                debounce FSM state encoding and counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_debounce_pkg;

    // Width of both the stability counter and the toggle counter.
    localparam int C_COUNT_WIDTH = 16;

    // Debounce FSM states. PEND_* states are "candidate level seen, waiting
    // for it to stay put long enough".
    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_PEND_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_PEND_LO   = 2'd3
    } state_t;

endpackage : sync_debounce_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_chain
//  Description : Multi-flop synchroniser for a single asynchronous level.
//                Every stage is an asynchronously reset flop that resets to
//                RESET_VALUE, so the chain output is well defined in reset.
//  Ports       : CLK       - destination clock
//                RST_IN    - asynchronous active-high reset
//                ASYNC_IN  - level from another domain / a pin
//                SYNC_OUT  - synchronised level (last stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int   DEPTH       = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic CLK,
    input  logic RST_IN,
    input  logic ASYNC_IN,
    output logic SYNC_OUT
);

    logic [DEPTH-1:0] r_stage;

    // Stage 0 is the only flop that sees the asynchronous input.
    always_ff @(posedge CLK or posedge RST_IN) begin
        if (RST_IN) begin
            r_stage <= {DEPTH{RESET_VALUE}};
        end else begin
            r_stage <= {r_stage[DEPTH-2:0], ASYNC_IN};
        end
    end

    assign SYNC_OUT = r_stage[DEPTH-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sync_debounce
//  Description : Synchronises an asynchronous level, filters glitches by
//                requiring C_STABLE_CYCLES equal samples before accepting a
//                change, and reports accepted edges plus a saturating count.
//  Ports       : CLK          - sole clock, rising edge
//                RST_IN       - asynchronous active-high reset
//                ASYNC_IN     - raw level, may glitch
//                CLR_COUNT    - synchronous clear of TOGGLE_COUNT
//                LEVEL_OUT    - filtered level (registered)
//                RISE_OUT     - one-cycle pulse on accepted 0->1
//                FALL_OUT     - one-cycle pulse on accepted 1->0
//                TOGGLE_COUNT - saturating count of accepted transitions
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int C_SYNC_STAGES   = 2,
    parameter int C_STABLE_CYCLES = 16,
    parameter int C_RESET_VALUE   = 0
) (
    input  logic                     CLK,
    input  logic                     RST_IN,
    input  logic                     ASYNC_IN,
    input  logic                     CLR_COUNT,
    output logic                     LEVEL_OUT,
    output logic                     RISE_OUT,
    output logic                     FALL_OUT,
    output logic [C_COUNT_WIDTH-1:0] TOGGLE_COUNT
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (C_SYNC_STAGES < 2 || C_SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("sync_debounce: C_SYNC_STAGES=%0d outside 2..4", C_SYNC_STAGES);
    end
    if (C_STABLE_CYCLES < 2 || C_STABLE_CYCLES > 65535) begin : g_bad_stable_cycles
        $error("sync_debounce: C_STABLE_CYCLES=%0d outside 2..65535", C_STABLE_CYCLES);
    end
    if (C_RESET_VALUE != 0 && C_RESET_VALUE != 1) begin : g_bad_reset_value
        $error("sync_debounce: C_RESET_VALUE=%0d must be 0 or 1", C_RESET_VALUE);
    end

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic                     c_rst_level = (C_RESET_VALUE != 0);
    localparam state_t                   c_rst_state = c_rst_level ? ST_STABLE_HI : ST_STABLE_LO;
    localparam logic [C_COUNT_WIDTH-1:0] c_cnt_last  = C_COUNT_WIDTH'(C_STABLE_CYCLES - 1);
    localparam logic [C_COUNT_WIDTH-1:0] c_cnt_one   = C_COUNT_WIDTH'(1);
    localparam logic [C_COUNT_WIDTH-1:0] c_cnt_max   = '1;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic w_sync;

    sync_chain #(
        .DEPTH       (C_SYNC_STAGES),
        .RESET_VALUE (c_rst_level)
    ) u_sync_chain (
        .CLK      (CLK),
        .RST_IN   (RST_IN),
        .ASYNC_IN (ASYNC_IN),
        .SYNC_OUT (w_sync)
    );

    // ------------------------------------------------------------------
    // Debounce FSM with registered outputs
    // ------------------------------------------------------------------
    state_t                   r_state;
    logic [C_COUNT_WIDTH-1:0] r_cnt;
    logic                     r_level;
    logic                     r_rise;
    logic                     r_fall;

    // The first sample that differs from the stable level already counts as
    // one, so acceptance happens when the counter reaches C_STABLE_CYCLES-1
    // while the sample is still the new level.
    always_ff @(posedge CLK or posedge RST_IN) begin
        if (RST_IN) begin
            r_state <= c_rst_state;
            r_cnt   <= '0;
            r_level <= c_rst_level;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_STABLE_LO: begin
                    if (w_sync) begin
                        r_state <= ST_PEND_HI;
                        r_cnt   <= c_cnt_one;
                    end
                end
                ST_PEND_HI: begin
                    if (!w_sync) begin
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= ST_STABLE_HI;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_STABLE_HI: begin
                    if (!w_sync) begin
                        r_state <= ST_PEND_LO;
                        r_cnt   <= c_cnt_one;
                    end
                end
                ST_PEND_LO: begin
                    if (w_sync) begin
                        r_state <= ST_STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= c_rst_state;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Toggle counter: counts the registered pulses, so it moves one cycle
    // after each pulse. Clear takes priority over an increment.
    // ------------------------------------------------------------------
    logic [C_COUNT_WIDTH-1:0] r_toggle_count;

    always_ff @(posedge CLK or posedge RST_IN) begin
        if (RST_IN) begin
            r_toggle_count <= '0;
        end else if (CLR_COUNT) begin
            r_toggle_count <= '0;
        end else if ((r_rise || r_fall) && (r_toggle_count != c_cnt_max)) begin
            r_toggle_count <= r_toggle_count + c_cnt_one;
        end
    end

    assign LEVEL_OUT    = r_level;
    assign RISE_OUT     = r_rise;
    assign FALL_OUT     = r_fall;
    assign TOGGLE_COUNT = r_toggle_count;

endmodule : sync_debounce
`default_nettype wire

// File: tb/tb_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_debounce
//  Description : Directed self-checking bench for sync_debounce. Instance A
//                uses reset value 0, instance B reset value 1; both use two
//                sync stages and a stability window of four samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_debounce;

    logic        clk = 1'b0;
    logic        rst_a, async_a, clr_a;
    logic        level_a, rise_a, fall_a;
    logic [15:0] count_a;
    logic        rst_b, async_b, clr_b;
    logic        level_b, rise_b, fall_b;
    logic [15:0] count_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_debounce #(
        .C_SYNC_STAGES   (2),
        .C_STABLE_CYCLES (4),
        .C_RESET_VALUE   (0)
    ) dut_a (
        .CLK          (clk),
        .RST_IN       (rst_a),
        .ASYNC_IN     (async_a),
        .CLR_COUNT    (clr_a),
        .LEVEL_OUT    (level_a),
        .RISE_OUT     (rise_a),
        .FALL_OUT     (fall_a),
        .TOGGLE_COUNT (count_a)
    );

    sync_debounce #(
        .C_SYNC_STAGES   (2),
        .C_STABLE_CYCLES (4),
        .C_RESET_VALUE   (1)
    ) dut_b (
        .CLK          (clk),
        .RST_IN       (rst_b),
        .ASYNC_IN     (async_b),
        .CLR_COUNT    (clr_b),
        .LEVEL_OUT    (level_b),
        .RISE_OUT     (rise_b),
        .FALL_OUT     (fall_b),
        .TOGGLE_COUNT (count_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive instance A to level v and check the 7-edge response: level and
    // pulse at edge 6, counter update at edge 7.
    task automatic transit_a(input logic v, input logic [15:0] cnt_before,
                             input logic [15:0] cnt_after);
        async_a = v;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("a_level", {15'd0, level_a}, {15'd0, (e >= 6) ? v : ~v});
            chk("a_rise",  {15'd0, rise_a},  {15'd0, (v && e == 6)});
            chk("a_fall",  {15'd0, fall_a},  {15'd0, (!v && e == 6)});
            chk("a_count", count_a, (e >= 7) ? cnt_after : cnt_before);
        end
    endtask

    initial begin
        rst_a = 1'b1; async_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b1; async_b = 1'b1; clr_b = 1'b0;

        // Reset values
        tick(); tick();
        chk("a_rst_level", {15'd0, level_a}, 16'd0);
        chk("a_rst_rise",  {15'd0, rise_a},  16'd0);
        chk("a_rst_fall",  {15'd0, fall_a},  16'd0);
        chk("a_rst_count", count_a,          16'd0);
        chk("b_rst_level", {15'd0, level_b}, 16'd1);
        chk("b_rst_pulse", {14'd0, rise_b, fall_b}, 16'd0);
        chk("b_rst_count", count_b,          16'd0);

        // Release both; B keeps ASYNC_IN high through release
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_idle_level", {15'd0, level_a}, 16'd0);
            chk("b_hold_level", {15'd0, level_b}, 16'd1);
            chk("b_hold_pulse", {14'd0, rise_b, fall_b}, 16'd0);
        end

        // Accepted rise then accepted fall
        transit_a(1'b1, 16'd0, 16'd1);
        transit_a(1'b0, 16'd1, 16'd2);

        // Three-cycle glitch is rejected
        async_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("glitch_level", {15'd0, level_a}, 16'd0);
        end
        async_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("glitch_level", {15'd0, level_a}, 16'd0);
            chk("glitch_rise",  {15'd0, rise_a},  16'd0);
        end
        chk("glitch_count", count_a, 16'd2);

        // Reset while pending high (CNT=2 after the 4th edge)
        async_a = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pend_level", {15'd0, level_a}, 16'd0);
        async_a = 1'b0;
        rst_a   = 1'b1;
        #1;
        chk("prst_level", {15'd0, level_a}, 16'd0);
        chk("prst_pulse", {14'd0, rise_a, fall_a}, 16'd0);
        chk("prst_count", count_a, 16'd0);
        #2;
        rst_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_rise",  {15'd0, rise_a},  16'd0);
            chk("post_rst_level", {15'd0, level_a}, 16'd0);
        end

        // Saturation from a preset count
        @(negedge clk);
        force dut_a.r_toggle_count = 16'hFFFE;
        #1;
        release dut_a.r_toggle_count;
        tick();
        chk("preset_count", count_a, 16'hFFFE);
        transit_a(1'b1, 16'hFFFE, 16'hFFFF);
        transit_a(1'b0, 16'hFFFF, 16'hFFFF);
        transit_a(1'b1, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_hold", count_a, 16'hFFFF);

        // Clear coincident with a fall pulse wins
        async_a = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("clr_fall_pulse", {15'd0, fall_a}, 16'd1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        chk("clr_count", count_a, 16'd0);
        tick();
        chk("clr_count_hold", count_a, 16'd0);

        // Instance B: falls at edge 6 after ASYNC_IN goes low
        async_b = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk("b_level", {15'd0, level_b}, (e >= 6) ? 16'd0 : 16'd1);
            chk("b_fall",  {15'd0, fall_b},  (e == 6) ? 16'd1 : 16'd0);
            chk("b_rise",  {15'd0, rise_b},  16'd0);
        end
        chk("b_count", count_b, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sync_debounce
`default_nettype wire
